// File: rtl/cw_golomb_bitstream_dec_pkg.sv
// Shared types and helpers for the constant-weight Golomb bitstream decoder.
// Holds the FSM state encoding, default widths and the u saturation helper.
package cw_dec_pkg;

    localparam int CW_W_DEF = 11;
    localparam int U_W_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_QUOT = 3'd2,
        ST_SEP  = 3'd3,
        ST_REM  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // A remainder can never be wider than the delta symbol itself.
    function automatic int unsigned sat_u(input int unsigned u, input int unsigned cw_w = CW_W_DEF);
        return (u > cw_w) ? cw_w : u;
    endfunction

endpackage

// File: rtl/cw_golomb_bitstream_dec_sym_buf.sv
// Symbol buffer: simple dual-port RAM, one write port, one registered read port.
// A read of the address being written returns the new word (write-first).
module cw_sym_buf #(
    parameter int W     = 15,
    parameter int DEPTH = 32,
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [PTR_W-1:0] i_wr_addr,
    input  logic [W-1:0]     i_wr_data,
    input  logic [PTR_W-1:0] i_rd_addr,
    output logic [W-1:0]     o_rd_data
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rd_data;

    // Write port
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read; bypass lets a same-cycle write+start read symbol 0 correctly
    always_ff @(posedge clk) begin
        if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
            r_rd_data <= i_wr_data;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cw_golomb_bitstream_dec.sv
// Constant-weight Golomb bitstream decoder: buffers (u, delta) symbols and emits
// floor(delta/2^u) ones, a zero, then the u low bits of delta on a valid/ready stream.
module cw_golomb_bitstream_dec
    import cw_dec_pkg::*;
#(
    parameter int CW_W  = CW_W_DEF,
    parameter int U_W   = U_W_DEF,
    parameter int DEPTH = 32,
    parameter int PTR_W = 5
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            wr_en,
    input  logic [CW_W-1:0] msg_byte,
    input  logic [U_W-1:0]  u_in,
    input  logic            start,
    input  logic            bin_ready,
    output logic            bin_msg,
    output logic            msg_rdy,
    output logic            msg_done,
    output logic            busy,
    output logic            full,
    output logic            err_ovf
);

    localparam int K_W = $clog2(CW_W + 1);
    localparam int E_W = U_W + CW_W;

    state_t             r_state, w_state_nxt, w_sym_state;
    logic [PTR_W-1:0]   r_wr_ptr, w_wr_ptr_nxt, r_rd_ptr, w_rd_ptr_nxt, w_sym_rd_ptr;
    logic [PTR_W:0]     r_count, w_count_nxt, w_cnt_wr;
    logic [CW_W-1:0]    r_q, w_q_nxt, r_rem, w_rem_nxt, w_mask, w_rem_shift;
    logic [K_W-1:0]     r_us, w_us_nxt, r_k, w_k_nxt, w_load_us, w_idx;
    logic [E_W-1:0]     w_rd_data;
    logic [U_W-1:0]     w_rd_u;
    logic [CW_W-1:0]    w_rd_d;
    logic               r_bin_msg, r_msg_rdy, r_msg_done, r_busy, r_full, r_err_ovf;
    logic               w_full, w_wr_ok, w_acc, w_last_sym, w_bit_nxt, w_ovf_nxt;

    cw_sym_buf #(
        .W     (E_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_sym_buf (
        .clk       (clk),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data ({u_in, msg_byte}),
        .i_rd_addr (w_rd_ptr_nxt),
        .o_rd_data (w_rd_data)
    );

    assign w_full     = (r_count == (PTR_W+1)'(DEPTH));
    assign w_wr_ok    = wr_en && (r_state == ST_IDLE) && !w_full;
    assign w_ovf_nxt  = r_err_ovf | (wr_en && (r_state == ST_IDLE) && w_full);
    assign w_acc      = r_msg_rdy && bin_ready;
    assign w_last_sym = (({1'b0, r_rd_ptr} + (PTR_W+1)'(1)) == r_count);
    assign {w_rd_u, w_rd_d} = w_rd_data;
    assign w_load_us  = K_W'(sat_u(32'(w_rd_u), CW_W));
    // All-ones when u_s == CW_W because the shifted 1 falls off the top
    assign w_mask     = (CW_W'(1) << w_load_us) - CW_W'(1);
    assign w_sym_state  = w_last_sym ? ST_DONE : ST_LOAD;
    assign w_sym_rd_ptr = w_last_sym ? r_rd_ptr : (r_rd_ptr + PTR_W'(1));

    // Next-state, pointer and per-symbol counter logic
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_q_nxt      = r_q;
        w_rem_nxt    = r_rem;
        w_us_nxt     = r_us;
        w_k_nxt      = r_k;
        w_cnt_wr     = r_count;
        if (w_wr_ok) begin
            w_cnt_wr     = r_count + (PTR_W+1)'(1);
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
        end else begin
            w_cnt_wr     = r_count;
        end
        w_count_nxt = w_cnt_wr;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_rd_ptr_nxt = PTR_W'(0);
                    w_state_nxt  = (w_cnt_wr != (PTR_W+1)'(0)) ? ST_LOAD : ST_DONE;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_us_nxt    = w_load_us;
                w_q_nxt     = w_rd_d >> w_load_us;
                w_rem_nxt   = w_rd_d & w_mask;
                w_k_nxt     = K_W'(0);
                w_state_nxt = ((w_rd_d >> w_load_us) != CW_W'(0)) ? ST_QUOT : ST_SEP;
            end
            ST_QUOT: begin
                if (w_acc) begin
                    w_q_nxt     = r_q - CW_W'(1);
                    w_state_nxt = (r_q == CW_W'(1)) ? ST_SEP : ST_QUOT;
                end else begin
                    w_state_nxt = ST_QUOT;
                end
            end
            ST_SEP: begin
                if (w_acc && (r_us != K_W'(0))) begin
                    w_k_nxt     = K_W'(0);
                    w_state_nxt = ST_REM;
                end else if (w_acc) begin
                    w_rd_ptr_nxt = w_sym_rd_ptr;
                    w_state_nxt  = w_sym_state;
                end else begin
                    w_state_nxt  = ST_SEP;
                end
            end
            ST_REM: begin
                if (w_acc && (r_k == (r_us - K_W'(1)))) begin
                    w_rd_ptr_nxt = w_sym_rd_ptr;
                    w_state_nxt  = w_sym_state;
                end else if (w_acc) begin
                    w_k_nxt      = r_k + K_W'(1);
                end else begin
                    w_state_nxt  = ST_REM;
                end
            end
            ST_DONE: begin
                w_state_nxt  = ST_IDLE;
                w_wr_ptr_nxt = PTR_W'(0);
                w_rd_ptr_nxt = PTR_W'(0);
                w_count_nxt  = (PTR_W+1)'(0);
            end
            default: begin
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    assign w_idx       = w_us_nxt - K_W'(1) - w_k_nxt;
    assign w_rem_shift = w_rem_nxt >> w_idx;

    // Bit value presented on the stream in the coming cycle
    always_comb begin
        w_bit_nxt = 1'b0;
        case (w_state_nxt)
            ST_QUOT: w_bit_nxt = 1'b1;
            ST_REM:  w_bit_nxt = w_rem_shift[0];
            default: w_bit_nxt = 1'b0;
        endcase
    end

    // State, datapath and registered output update
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= PTR_W'(0);
            r_rd_ptr   <= PTR_W'(0);
            r_count    <= (PTR_W+1)'(0);
            r_q        <= CW_W'(0);
            r_rem      <= CW_W'(0);
            r_us       <= K_W'(0);
            r_k        <= K_W'(0);
            r_bin_msg  <= 1'b0;
            r_msg_rdy  <= 1'b0;
            r_msg_done <= 1'b0;
            r_busy     <= 1'b0;
            r_full     <= 1'b0;
            r_err_ovf  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_q        <= w_q_nxt;
            r_rem      <= w_rem_nxt;
            r_us       <= w_us_nxt;
            r_k        <= w_k_nxt;
            r_bin_msg  <= w_bit_nxt;
            r_msg_rdy  <= (w_state_nxt == ST_QUOT) || (w_state_nxt == ST_SEP) || (w_state_nxt == ST_REM);
            r_msg_done <= (w_state_nxt == ST_DONE);
            r_busy     <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_QUOT) ||
                          (w_state_nxt == ST_SEP)  || (w_state_nxt == ST_REM);
            r_full     <= (w_count_nxt == (PTR_W+1)'(DEPTH));
            r_err_ovf  <= w_ovf_nxt;
        end
    end

    assign bin_msg  = r_bin_msg;
    assign msg_rdy  = r_msg_rdy;
    assign msg_done = r_msg_done;
    assign busy     = r_busy;
    assign full     = r_full;
    assign err_ovf  = r_err_ovf;

endmodule

// File: tb/tb_cw_golomb_bitstream_dec.sv
// Directed self-checking bench for cw_golomb_bitstream_dec.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_cw_golomb_bitstream_dec;

    localparam int CW = 11;

    logic          clk, rst_b, wr_en, start, bin_ready;
    logic [CW-1:0] msg_byte;
    logic [3:0]    u_in;
    logic          bin_msg, msg_rdy, msg_done, busy, full, err_ovf;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_q[$];

    cw_golomb_bitstream_dec dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .wr_en     (wr_en),
        .msg_byte  (msg_byte),
        .u_in      (u_in),
        .start     (start),
        .bin_ready (bin_ready),
        .bin_msg   (bin_msg),
        .msg_rdy   (msg_rdy),
        .msg_done  (msg_done),
        .busy      (busy),
        .full      (full),
        .err_ovf   (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b1;
        tick();
        tick();
        rst_b = 1'b0;
    endtask

    task automatic write_sym(input int d, input int u);
        wr_en    = 1'b1;
        msg_byte = CW'(d);
        u_in     = 4'(u);
        tick();
        wr_en    = 1'b0;
    endtask

    // Reference Golomb encoder for one symbol
    task automatic add_exp(input int d, input int u);
        int us;
        us = (u > CW) ? CW : u;
        for (int i = 0; i < (d >> us); i++) exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        for (int b = us - 1; b >= 0; b--) exp_q.push_back(1'((d >> b) & 1));
    endtask

    task automatic load_hand(input logic [31:0] v, input int n);
        exp_q.delete();
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i]);
    endtask

    // Start a run, collect the stream and check it against exp_q
    task automatic run_stream(input string name, input int stall_bit, input int stall_len,
                              input int extra_start_cyc, input int exp_done);
        logic got_q[$];
        int   cyc, done_cyc, stall_left;
        bit   done_seen;
        stall_left = stall_len;
        done_seen  = 1'b0;
        done_cyc   = -1;
        start      = 1'b1;
        bin_ready  = 1'b1;
        tick();
        start      = 1'b0;
        cyc        = 1;
        n_checks++;
        if (busy !== 1'b1 || msg_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_load busy=%b msg_rdy=%b expected busy=1 msg_rdy=0", name, busy, msg_rdy);
        end
        while (!done_seen && cyc < 3000) begin
            if (msg_done === 1'b1) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end else begin
                bin_ready = 1'b1;
                if (got_q.size() == stall_bit && stall_left > 0 &&
                    (msg_rdy === 1'b1 || stall_left < stall_len)) begin
                    bin_ready = 1'b0;
                    stall_left--;
                    n_checks++;
                    if (msg_rdy !== 1'b1 || bin_msg !== exp_q[stall_bit]) begin
                        n_fail++;
                        $display("FAIL %s_stall cyc=%0d msg_rdy=%b bin_msg=%b expected 1/%b",
                                 name, cyc, msg_rdy, bin_msg, exp_q[stall_bit]);
                    end
                end else if (msg_rdy === 1'b1) begin
                    got_q.push_back(bin_msg);
                end
                start    = (cyc == extra_start_cyc);
                wr_en    = (cyc == extra_start_cyc);
                msg_byte = CW'(1);
                u_in     = 4'(0);
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        n_checks++;
        if (!done_seen) begin
            n_fail++;
            $display("FAIL %s_timeout no msg_done within %0d cycles", name, cyc);
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_nbits got=%0d expected=%0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_bit%0d got=%b expected=%b", name, i, got_q[i], exp_q[i]);
            end
        end
        if (exp_done >= 0) begin
            n_checks++;
            if (done_cyc != exp_done) begin
                n_fail++;
                $display("FAIL %s_done_cycle got=%0d expected=%0d", name, done_cyc, exp_done);
            end
        end
        tick();
        n_checks++;
        if (msg_done !== 1'b0 || busy !== 1'b0 || msg_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_post done=%b busy=%b rdy=%b expected 0/0/0", name, msg_done, busy, msg_rdy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bin_msg, msg_rdy, msg_done, busy, full, err_ovf} !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset outs=%b expected=000000",
                     {bin_msg, msg_rdy, msg_done, busy, full, err_ovf});
        end
    endtask

    task automatic test_empty_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (msg_done !== 1'b1 || busy !== 1'b0 || msg_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_start done=%b busy=%b rdy=%b expected 1/0/0", msg_done, busy, msg_rdy);
        end
        tick();
        n_checks++;
        if (msg_done !== 1'b0 || msg_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_after done=%b rdy=%b expected 0/0", msg_done, msg_rdy);
        end
    endtask

    task automatic test_basic();
        write_sym(6, 2);
        load_hand(32'b1010, 4);
        run_stream("basic", -1, 0, -1, 6);
    endtask

    task automatic test_multi();
        write_sym(0, 0);
        write_sym(120, 4);
        write_sym(5, 3);
        load_hand(32'b0_1111111_0_1000_0_101, 17);
        run_stream("multi", -1, 0, -1, 21);
    endtask

    task automatic test_backpressure();
        write_sym(6, 2);
        load_hand(32'b1010, 4);
        run_stream("bp", 1, 3, -1, 9);
    endtask

    task automatic test_sat();
        write_sym(2047, 15);
        load_hand(32'b0111_1111_1111, 12);
        run_stream("sat", -1, 0, -1, 14);
    endtask

    task automatic test_start_during_run();
        write_sym(6, 2);
        load_hand(32'b1010, 4);
        run_stream("start_busy", -1, 0, 3, 6);
        test_empty_start();
    endtask

    task automatic test_overflow();
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            write_sym(i & 7, i % 3);
            add_exp(i & 7, i % 3);
            if (i == 30) begin
                n_checks++;
                if (full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_full31 got=%b expected=0", full);
                end
            end
        end
        n_checks++;
        if (full !== 1'b1 || err_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full32 full=%b err=%b expected 1/0", full, err_ovf);
        end
        write_sym(7, 0);
        n_checks++;
        if (full !== 1'b1 || err_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_err33 full=%b err=%b expected 1/1", full, err_ovf);
        end
        run_stream("ovf", -1, 0, -1, 1 + 32 + exp_q.size());
        n_checks++;
        if (full !== 1'b0 || err_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_after full=%b err=%b expected 0/1", full, err_ovf);
        end
    endtask

    task automatic test_reset_mid_run();
        bit saw_done;
        do_reset();
        write_sym(3, 0);
        write_sym(5, 0);
        start     = 1'b1;
        bin_ready = 1'b1;
        tick();
        start     = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        n_checks++;
        if (msg_rdy !== 1'b1 || bin_msg !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_quot rdy=%b bit=%b busy=%b expected 1/1/1", msg_rdy, bin_msg, busy);
        end
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        n_checks++;
        if ({bin_msg, msg_rdy, msg_done, busy, full, err_ovf} !== 6'b000000) begin
            n_fail++;
            $display("FAIL midrun_reset outs=%b expected=000000",
                     {bin_msg, msg_rdy, msg_done, busy, full, err_ovf});
        end
        saw_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (msg_done === 1'b1 || msg_rdy === 1'b1) saw_done = 1'b1;
            tick();
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL midrun_quiet activity after reset got=1 expected=0");
        end
        test_basic();
    endtask

    initial begin
        rst_b     = 1'b1;
        wr_en     = 1'b0;
        start     = 1'b0;
        bin_ready = 1'b0;
        msg_byte  = CW'(0);
        u_in      = 4'(0);
        test_reset();
        test_empty_start();
        test_basic();
        test_multi();
        test_backpressure();
        test_sat();
        test_start_during_run();
        test_overflow();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cw_golomb_bitstream_dec.md
Name: cw_golomb_bitstream_dec

Overview:
- Parametrised successor to the constant-weight decoder front end. It buffers a block of constant-weight delta symbols, each with its own Golomb parameter u.
- On start it converts each symbol to its binary-message bits: floor(delta/2^u) ones, a zero separator, then the u low bits of delta, MSB first.
- Bits leave on a serial valid/ready stream toward the message sink.
- Adds over the previous generation: a runtime symbol count, per-symbol u, output backpressure and overflow flagging.

Parameters:
- CW_W, 11, width of one delta symbol.
- U_W, 4, width of the per-symbol u field; u values above CW_W saturate to CW_W.
- DEPTH, 32, symbol buffer depth in entries; must be a power of 2.
- PTR_W, 5, log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_b  in  1  reset, synchronous, active-high (the port keeps the codebase name).
- wr_en  in  1  write one symbol into the buffer.
- msg_byte  in  CW_W  delta value written with wr_en.
- u_in  in  U_W  Golomb parameter written with wr_en.
- start  in  1  one-cycle pulse that begins decoding of the buffered symbols.
- bin_ready  in  1  sink accepts the current bit.
- bin_msg  out  1  current message bit.
- msg_rdy  out  1  bin_msg valid.
- msg_done  out  1  one-cycle pulse after the last bit is accepted.
- busy  out  1  high from an accepted start until msg_done.
- full  out  1  buffer holds DEPTH symbols.
- err_ovf  out  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset: clears all outputs to 0, clears write/read pointers and the symbol count, and puts the FSM in IDLE. The RAM contents are don't-care.
- A reset asserted mid-run aborts the run. No msg_done is produced.
- Writes:
  - Accepted only in IDLE with full=0. {u_in, msg_byte} is stored at wr_ptr, wr_ptr increments and count increments.
  - A write while full is dropped and sets err_ovf.
  - A write while busy is dropped silently.
  - err_ovf clears only on reset.
- Start: honoured only in IDLE. If wr_en and start arrive in the same cycle, the write is stored first and the start uses the updated count. Start while busy is ignored.
- Empty start: start with count=0 gives a msg_done pulse on the next cycle, busy stays 0, and no bits are emitted.
- FSM states: IDLE, LOAD, QUOT, SEP, REM, DONE.
  - IDLE -> LOAD on start with count>0. busy=1 and rd_ptr=0.
  - LOAD (1 cycle, synchronous RAM read): latch d, u_s=min(u,CW_W), q=d>>u_s, r=d & (2^u_s - 1). Next state is QUOT if q>0, else SEP.
  - QUOT: bin_msg=1 and msg_rdy=1. On each accept (msg_rdy & bin_ready), q decrements. After the accept at q=1, go to SEP.
  - SEP: bin_msg=0. On accept, go to REM if u_s>0, else to the next symbol.
  - REM: bin_msg=r[u_s-1-k], with bit counter k from 0 to u_s-1. After the accept at k=u_s-1, go to the next symbol.
  - Next symbol: rd_ptr+1. If rd_ptr+1==count, go to DONE; otherwise go to LOAD.
  - DONE: msg_done=1 for one cycle, busy=0, pointers and count cleared, then IDLE.
- Latency: start accepted at cycle 0, LOAD at cycle 1, first msg_rdy at cycle 2. Each symbol costs 1 LOAD cycle plus one cycle per bit with bin_ready held high.
- Backpressure: while msg_rdy=1 and bin_ready=0, bin_msg, the state and all counters hold. msg_rdy never drops before an accept.
- Width rules:
  - q counter is CW_W bits; the maximum is 2^CW_W - 1 when u=0.
  - k counter is clog2(CW_W+1) bits.
  - Total bits per symbol: q + 1 + u_s.
- Pointer wrap: write and read pointers are PTR_W bits. count is PTR_W+1 bits so that full means count==DEPTH.

Decomposition:
- Package cw_dec_pkg holds:
  - FSM state typedef/localparams (IDLE, LOAD, QUOT, SEP, REM, DONE).
  - Default CW_W/U_W constants.
  - A function sat_u(u) returning min(u,CW_W).
- Sub-module cw_sym_buf: a DEPTH x (U_W+CW_W) simple dual-port RAM with a synchronous 1-cycle read, one write port and one read port.
- The FSM, counters and output logic live in the top module.

Test Plan:
- Basic symbol: write (msg_byte=6, u=2), start, bin_ready=1 -> bits 1,0,1,0 on cycles 2..5, then msg_done at cycle 6.
- Multi-symbol mix: write (0,u=0), (120,u=4), (5,u=3) -> 0 | 1111111 0 1000 | 0 101. That is 17 bits total, LOAD bubbles between symbols, one msg_done.
- Backpressure: same as the basic symbol, with bin_ready low for 3 cycles while the second bit is presented -> bin_msg stays 0 and msg_rdy stays 1, and the stream is otherwise identical.
- Overflow: write 33 symbols with DEPTH=32 -> full=1 after the 32nd write and err_ovf=1 after the 33rd. Start -> exactly 32 symbols are decoded.
- Corner cases:
  - start with an empty buffer -> msg_done next cycle, no msg_rdy.
  - start during a run -> ignored.
  - u=15 with delta=2047 -> u_s saturates to 11, giving 0 followed by eleven 1s.
- Reset mid-run: assert rst_b during QUOT of the second symbol -> all outputs 0 on the next cycle, no msg_done. A new write/start cycle then decodes correctly.
